// File: rtl/ipv4_header_extractor.sv
// rtl/ipv4_header_extractor.sv - captures the 40 IPv4/TCP header bytes of each Ethernet frame into one output word
module ipv4_header_extractor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  input  logic [63:0]      in_data,
  input  logic [2:0]       in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [319:0]     out_data,
  output logic [CNT_W-1:0] hdr_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD, SKIP} state_t;

  state_t       state, state_nx;
  logic [2:0]   k, k_nx;
  logic         eop_seen, eop_seen_nx;
  logic [319:0] hdr;
  logic [1:0]   drop_inc;
  logic [CNT_W:0] drop_sum;
  logic         fire;
  logic         hdr_ok;

  assign fire   = in_valid && in_ready;
  // EtherType and IP version both live in beat1
  assign hdr_ok = (in_data[31:16] == 16'h0800) && (in_data[15:12] == 4'h4);

  assign out_valid         = (state == HOLD);
  assign out_startofpacket = out_valid;
  assign out_endofpacket   = out_valid;
  assign out_data          = hdr;

  // next-state, beat index and drop accounting; a restart with a one-beat frame can drop two frames at once
  always_comb begin
    state_nx    = state;
    k_nx        = k;
    eop_seen_nx = eop_seen;
    drop_inc    = 2'd0;
    case (state)
      IDLE: begin
        if (fire && in_startofpacket) begin
          if (in_endofpacket) begin
            drop_inc = 2'd1;
          end else begin
            state_nx = COLLECT;
            k_nx     = 3'd1;
          end
        end
      end
      COLLECT: begin
        if (fire) begin
          if (in_startofpacket) begin
            if (in_endofpacket) begin
              drop_inc = 2'd2;
              state_nx = IDLE;
            end else begin
              drop_inc = 2'd1;
              k_nx     = 3'd1;
            end
          end else if (k == 3'd1 && !hdr_ok) begin
            drop_inc = 2'd1;
            state_nx = in_endofpacket ? IDLE : SKIP;
          end else if (k == 3'd6) begin
            if (in_endofpacket && in_empty > 3'd2) begin
              drop_inc = 2'd1;
              state_nx = IDLE;
            end else begin
              state_nx    = HOLD;
              eop_seen_nx = in_endofpacket;
            end
          end else if (in_endofpacket) begin
            drop_inc = 2'd1;
            state_nx = IDLE;
          end else if (k != 3'd7) begin
            k_nx = k + 3'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nx = eop_seen ? IDLE : SKIP;
      end
      SKIP: begin
        if (fire) begin
          if (in_startofpacket) begin
            if (in_endofpacket) begin
              drop_inc = 2'd1;
              state_nx = IDLE;
            end else begin
              state_nx = COLLECT;
              k_nx     = 3'd1;
            end
          end else if (in_endofpacket) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, drop_inc};

  // state register; in_ready is decoded from the next state so it is a clean flop output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      k        <= 3'd0;
      eop_seen <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      k        <= k_nx;
      eop_seen <= eop_seen_nx;
      in_ready <= (state_nx != HOLD);
    end
  end

  // header capture: header byte h is frame byte h+14, so beat1 contributes its last two bytes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr <= '0;
    end else if (state == COLLECT && fire && !in_startofpacket) begin
      case (k)
        3'd1: hdr[319:304] <= in_data[15:0];
        3'd2: hdr[303:240] <= in_data;
        3'd3: hdr[239:176] <= in_data;
        3'd4: hdr[175:112] <= in_data;
        3'd5: hdr[111:48]  <= in_data;
        3'd6: hdr[47:0]    <= in_data[63:16];
        default: ;
      endcase
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_count  <= '0;
      drop_count <= '0;
    end else begin
      if (out_valid && out_ready && hdr_count != {CNT_W{1'b1}}) hdr_count <= hdr_count + 1'b1;
      if (drop_sum[CNT_W]) drop_count <= {CNT_W{1'b1}};
      else                 drop_count <= drop_sum[CNT_W-1:0];
    end
  end

endmodule
